// File: rtl/audio_i2s_if_if.sv
// rtl/audio_i2s_if_if.sv - sample-pair stream bundle between audio_i2s_if and its user
//
// Purpose: carries the DAC pair handshake into the I2S block and the ADC pair,
// its strobe and the underrun strobe back out.
// Signals (direction as seen from audio_i2s_if, i.e. the slave modport):
//   dac_valid_i  in   DAC pair offered
//   dac_left_i   in   DAC left sample, two's complement
//   dac_right_i  in   DAC right sample
//   dac_ready_o  out  holding register empty; pair accepted when valid & ready
//   adc_valid_o  out  1-cycle strobe: adc_left_o/adc_right_o hold a new pair
//   adc_left_o   out  ADC left sample
//   adc_right_o  out  ADC right sample
//   underrun_o   out  1-cycle strobe: frame started with empty holding register
interface audio_i2s_if_if #(
    parameter int DATA_W = 16
);
    logic              dac_valid_i;
    logic [DATA_W-1:0] dac_left_i;
    logic [DATA_W-1:0] dac_right_i;
    logic              dac_ready_o;
    logic              adc_valid_o;
    logic [DATA_W-1:0] adc_left_o;
    logic [DATA_W-1:0] adc_right_o;
    logic              underrun_o;

    modport slave (
        input  dac_valid_i, dac_left_i, dac_right_i,
        output dac_ready_o, adc_valid_o, adc_left_o, adc_right_o, underrun_o
    );

    modport master (
        output dac_valid_i, dac_left_i, dac_right_i,
        input  dac_ready_o, adc_valid_o, adc_left_o, adc_right_o, underrun_o
    );
endinterface

// File: rtl/audio_i2s_if.sv
// rtl/audio_i2s_if.sv - I2S master link to the WM8731 codec
//
// Purpose: generates XCK/BCLK/LRCK, serialises DAC pairs onto DACDAT and
// deserialises ADCDAT into pairs, running only while en_i & cf_done_i.
// Ports:
//   clk_50mhz      in   system clock
//   rst_i          in   synchronous reset, active-high
//   en_i           in   block enable
//   cf_done_i      in   codec configuration finished
//   stream_if      slave  DAC pair handshake in, ADC pair / underrun out
//   aud_xck_o      out  codec master clock, clk/4
//   aud_bclk_o     out  bit clock
//   aud_daclrck_o  out  DAC LR clock, 0 = left slot
//   aud_adclrck_o  out  ADC LR clock, same as aud_daclrck_o
//   aud_dacdat_o   out  serial DAC data
//   aud_adcdat_i   in   serial ADC data, asynchronous
module audio_i2s_if #(
    parameter int DATA_W    = 16,
    parameter int SLOT_W    = 32,
    parameter int BCLK_HALF = 8
) (
    input  logic          clk_50mhz,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          cf_done_i,
    audio_i2s_if_if.slave stream_if,
    output logic          aud_xck_o,
    output logic          aud_bclk_o,
    output logic          aud_daclrck_o,
    output logic          aud_adclrck_o,
    output logic          aud_dacdat_o,
    input  logic          aud_adcdat_i
);

    localparam int CNT_W = $clog2(2 * SLOT_W);
    localparam int DIV_W = $clog2(BCLK_HALF);

    localparam logic [CNT_W-1:0] SLOT_C     = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(2 * SLOT_W - 1);
    localparam logic [CNT_W-1:0] DATA_C     = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(BCLK_HALF - 1);
    localparam logic [DIV_W-1:0] DIV_ONE_C  = DIV_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        xck_cnt_q, xck_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]  bit_q, bit_d;
    logic              bclk_q, bclk_d;
    logic              lrck_q, lrck_d;
    logic              dacdat_q, dacdat_d;
    logic [DATA_W-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
    logic [DATA_W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DATA_W-1:0] adc_l_q, adc_l_d, adc_r_q, adc_r_d;
    logic              adc_valid_q, adc_valid_d;
    logic              underrun_q, underrun_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d;

    logic              go;
    logic              accept;
    logic [CNT_W-1:0]  bit_nxt;
    logic              right_nxt;
    logic [CNT_W-1:0]  pos_nxt;
    logic [CNT_W-1:0]  pos_cur;
    logic              tx_slot;
    logic              rx_slot;
    logic              entry;
    logic              wrap;

    assign go     = en_i & cf_done_i;
    assign accept = stream_if.dac_valid_i & ~hold_full_q;

    // Position the next fall event moves to, and the slot position it implies.
    assign bit_nxt   = (bit_q == LAST_C) ? '0 : bit_q + CNT_ONE_C;
    assign right_nxt = (bit_nxt >= SLOT_C);
    assign pos_nxt   = right_nxt ? bit_nxt - SLOT_C : bit_nxt;
    // Slot position currently on the wire; lrck_q always tracks bit_q >= SLOT_W.
    assign pos_cur   = lrck_q ? bit_q - SLOT_C : bit_q;
    // Data occupies positions 1..DATA_W: the one-BCLK I2S delay leaves position 0 empty.
    assign tx_slot   = (pos_nxt != '0) && (pos_nxt <= DATA_C);
    assign rx_slot   = (pos_cur != '0) && (pos_cur <= DATA_C);

    always_comb begin
        state_d     = state_q;
        xck_cnt_d   = xck_cnt_q + 2'd1;
        div_d       = div_q;
        bit_d       = bit_q;
        bclk_d      = bclk_q;
        lrck_d      = lrck_q;
        dacdat_d    = dacdat_q;
        tx_l_d      = tx_l_q;
        tx_r_d      = tx_r_q;
        rx_l_d      = rx_l_q;
        rx_r_d      = rx_r_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        adc_l_d     = adc_l_q;
        adc_r_d     = adc_r_q;
        adc_valid_d = 1'b0;
        underrun_d  = 1'b0;
        sync1_d     = aud_adcdat_i;
        sync2_d     = sync1_q;
        entry       = 1'b0;
        wrap        = 1'b0;

        if (accept) begin
            hold_full_d = 1'b1;
            hold_l_d    = stream_if.dac_left_i;
            hold_r_d    = stream_if.dac_right_i;
        end

        case (state_q)
            ST_IDLE: begin
                div_d    = '0;
                bit_d    = '0;
                bclk_d   = 1'b0;
                lrck_d   = 1'b0;
                dacdat_d = 1'b0;
                rx_l_d   = '0;
                rx_r_d   = '0;
                if (go) begin
                    state_d = ST_RUN;
                    entry   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!go) begin
                    state_d  = ST_IDLE;
                    div_d    = '0;
                    bit_d    = '0;
                    bclk_d   = 1'b0;
                    lrck_d   = 1'b0;
                    dacdat_d = 1'b0;
                    rx_l_d   = '0;
                    rx_r_d   = '0;
                end else if (div_q != DIV_LAST_C) begin
                    div_d = div_q + DIV_ONE_C;
                end else begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    if (!bclk_q) begin
                        // Rise event: codec data is stable, sample it.
                        if (rx_slot) begin
                            if (lrck_q) begin
                                rx_r_d = (rx_r_q << 1) | DATA_W'(sync2_q);
                            end else begin
                                rx_l_d = (rx_l_q << 1) | DATA_W'(sync2_q);
                            end
                        end
                    end else begin
                        // Fall event: advance the bit position and drive the next bit.
                        bit_d    = bit_nxt;
                        lrck_d   = right_nxt;
                        dacdat_d = 1'b0;
                        if (tx_slot) begin
                            if (right_nxt) begin
                                dacdat_d = tx_r_q[DATA_W-1];
                                tx_r_d   = tx_r_q << 1;
                            end else begin
                                dacdat_d = tx_l_q[DATA_W-1];
                                tx_l_d   = tx_l_q << 1;
                            end
                        end
                        if (bit_q == LAST_C) begin
                            wrap        = 1'b1;
                            adc_l_d     = rx_l_q;
                            adc_r_d     = rx_r_q;
                            adc_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame boundary. An accept in this same cycle only happens when the
        // holding register was empty, so the boundary underruns and the new
        // pair waits for the next frame.
        if (entry || wrap) begin
            if (hold_full_q) begin
                tx_l_d      = hold_l_q;
                tx_r_d      = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                tx_l_d     = '0;
                tx_r_d     = '0;
                underrun_d = wrap;
            end
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            xck_cnt_q   <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            dacdat_q    <= 1'b0;
            tx_l_q      <= '0;
            tx_r_q      <= '0;
            rx_l_q      <= '0;
            rx_r_q      <= '0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            adc_l_q     <= '0;
            adc_r_q     <= '0;
            adc_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            xck_cnt_q   <= xck_cnt_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            dacdat_q    <= dacdat_d;
            tx_l_q      <= tx_l_d;
            tx_r_q      <= tx_r_d;
            rx_l_q      <= rx_l_d;
            rx_r_q      <= rx_r_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            adc_l_q     <= adc_l_d;
            adc_r_q     <= adc_r_d;
            adc_valid_q <= adc_valid_d;
            underrun_q  <= underrun_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
        end
    end

    assign aud_xck_o             = xck_cnt_q[1];
    assign aud_bclk_o            = bclk_q;
    assign aud_daclrck_o         = lrck_q;
    assign aud_adclrck_o         = lrck_q;
    assign aud_dacdat_o          = dacdat_q;
    assign stream_if.dac_ready_o = ~hold_full_q;
    assign stream_if.adc_valid_o = adc_valid_q;
    assign stream_if.adc_left_o  = adc_l_q;
    assign stream_if.adc_right_o = adc_r_q;
    assign stream_if.underrun_o  = underrun_q;

endmodule

// File: tb/tb_audio_i2s_if.sv
// tb/tb_audio_i2s_if.sv - self-checking bench for audio_i2s_if (loopback DACDAT -> ADCDAT)
module tb_audio_i2s_if;
    localparam int DATA_W = 16;
    localparam int FRAME  = 1024;

    logic clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    logic rst_i, en_i, cf_done_i;
    logic aud_xck, aud_bclk, aud_daclrck, aud_adclrck, aud_dacdat, aud_adcdat;

    audio_i2s_if_if #(.DATA_W(DATA_W)) sif ();

    assign aud_adcdat = aud_dacdat;

    audio_i2s_if #(.DATA_W(16), .SLOT_W(32), .BCLK_HALF(8)) dut (
        .clk_50mhz     (clk_50mhz),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .cf_done_i     (cf_done_i),
        .stream_if     (sif),
        .aud_xck_o     (aud_xck),
        .aud_bclk_o    (aud_bclk),
        .aud_daclrck_o (aud_daclrck),
        .aud_adclrck_o (aud_adclrck),
        .aud_dacdat_o  (aud_dacdat),
        .aud_adcdat_i  (aud_adcdat)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    always @(posedge clk_50mhz) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: actual %0h required %0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    // Reference model: outputs as a closed-form function of the cycle count since RUN entry.
    bit          m_on = 1'b0, m_run = 1'b0, m_full = 1'b0;
    int          m_k = 0, m_x = 0;
    logic [15:0] m_hl = '0, m_hr = '0, m_cl = '0, m_cr = '0;
    logic        e_bclk = 0, e_lrck = 0, e_dat = 0, e_xck = 0, e_ready = 1, e_av = 0, e_un = 0;
    logic [15:0] e_al = '0, e_ar = '0;
    bit          acc, bnd, wr;
    int          k, nf, bitn, p;

    // Monitors feeding the literal timing checks.
    logic prev_bclk = 0, prev_lrck = 0;
    int   last_bclk_rise = -1, last_lrck_rise = -1, last_valid = -1;
    bit   armed = 0;
    int   first_bclk = 0, first_dat = 0, first_valid = 0;
    logic [15:0] first_l = '0, first_r = '0;
    bit   count_un = 0, count_acc = 0;
    int   un_cnt = 0, acc_cnt = 0;

    initial begin
        forever begin
            @(negedge clk_50mhz);
            if (m_on) begin
                chk("bclk", aud_bclk, e_bclk);
                chk("daclrck", aud_daclrck, e_lrck);
                chk("adclrck", aud_adclrck, e_lrck);
                chk("dacdat", aud_dacdat, e_dat);
                chk("xck", aud_xck, e_xck);
                chk("dac_ready", sif.dac_ready_o, e_ready);
                chk("adc_valid", sif.adc_valid_o, e_av);
                chk("underrun", sif.underrun_o, e_un);
                chk("adc_left", sif.adc_left_o, e_al);
                chk("adc_right", sif.adc_right_o, e_ar);

                if (aud_bclk && !prev_bclk) begin
                    if (last_bclk_rise >= 0) chk("bclk_period", edge_cnt - last_bclk_rise, 16);
                    last_bclk_rise = edge_cnt;
                end
                if (aud_daclrck && !prev_lrck) begin
                    if (last_lrck_rise >= 0) chk("lrck_period", edge_cnt - last_lrck_rise, FRAME);
                    last_lrck_rise = edge_cnt;
                end
                if (sif.adc_valid_o) begin
                    if (last_valid >= 0) chk("valid_period", edge_cnt - last_valid, FRAME);
                    last_valid = edge_cnt;
                end
                if (armed) begin
                    if (first_bclk == 0 && aud_bclk) first_bclk = edge_cnt;
                    if (first_dat == 0 && aud_dacdat) first_dat = edge_cnt;
                    if (first_valid == 0 && sif.adc_valid_o) begin
                        first_valid = edge_cnt;
                        first_l     = sif.adc_left_o;
                        first_r     = sif.adc_right_o;
                    end
                end
                if (count_un && sif.underrun_o) un_cnt++;
                if (count_acc && sif.dac_valid_i && sif.dac_ready_o) acc_cnt++;
            end
            prev_bclk = aud_bclk;
            prev_lrck = aud_daclrck;

            // Advance the model across the coming rising edge.
            if (rst_i) begin
                m_on = 1; m_run = 0; m_x = 0; m_full = 0;
                e_bclk = 0; e_lrck = 0; e_dat = 0; e_xck = 0; e_ready = 1;
                e_av = 0; e_un = 0; e_al = '0; e_ar = '0;
                last_bclk_rise = -1; last_lrck_rise = -1; last_valid = -1;
            end else if (m_on) begin
                m_x   = (m_x + 1) % 4;
                e_xck = (m_x >= 2);
                e_av  = 0;
                e_un  = 0;
                acc   = sif.dac_valid_i && !m_full;
                bnd   = 0;
                wr    = 0;
                if (!m_run) begin
                    if (en_i && cf_done_i) begin
                        m_run = 1; m_k = 0; bnd = 1;
                    end
                end else if (!(en_i && cf_done_i)) begin
                    m_run = 0;
                end else begin
                    m_k++;
                    if (m_k % FRAME == 0) begin
                        wr = 1; bnd = 1;
                    end
                end
                if (wr) begin
                    e_av = 1; e_al = m_cl; e_ar = m_cr;
                end
                if (bnd) begin
                    if (m_full) begin
                        m_cl = m_hl; m_cr = m_hr; m_full = 0;
                    end else begin
                        m_cl = '0; m_cr = '0; e_un = wr;
                    end
                end
                if (acc) begin
                    m_full = 1; m_hl = sif.dac_left_i; m_hr = sif.dac_right_i;
                end
                e_ready = !m_full;
                if (m_run) begin
                    k      = m_k + 1;
                    nf     = (k - 1) / 16;
                    e_bclk = (((k - 1) / 8) % 2) == 1;
                    bitn   = nf % 64;
                    e_lrck = (bitn >= 32);
                    p      = bitn % 32;
                    if (p >= 1 && p <= 16) e_dat = e_lrck ? m_cr[16-p] : m_cl[16-p];
                    else e_dat = 0;
                end else begin
                    e_bclk = 0; e_lrck = 0; e_dat = 0;
                    last_bclk_rise = -1; last_lrck_rise = -1; last_valid = -1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_50mhz);
        #2;
    endtask

    task automatic rand_cycles(input int n, input int valid_mod);
        for (int i = 0; i < n; i++) begin
            sif.dac_valid_i = ($urandom % valid_mod) == 0;
            sif.dac_left_i  = 16'($urandom);
            sif.dac_right_i = 16'($urandom);
            step();
        end
    endtask

    int t0, t_drop;

    initial begin
        rst_i = 1; en_i = 0; cf_done_i = 0;
        sif.dac_valid_i = 0; sif.dac_left_i = '0; sif.dac_right_i = '0;
        repeat (4) @(posedge clk_50mhz);
        #2;
        chk("rst_ready", sif.dac_ready_o, 1);
        chk("rst_bclk", aud_bclk, 0);
        chk("rst_valid", sif.adc_valid_o, 0);
        rst_i = 0;

        // Enabled but codec not configured: link stays quiet.
        en_i = 1;
        repeat (40) step();
        chk("t1_bclk", aud_bclk, 0);
        chk("t1_lrck", aud_daclrck, 0);
        chk("t1_ready", sif.dac_ready_o, 1);

        // Loopback with a fixed pair offered continuously.
        sif.dac_valid_i = 1; sif.dac_left_i = 16'h8001; sif.dac_right_i = 16'h7FFE;
        step();
        chk("t2_ready_after_accept", sif.dac_ready_o, 0);
        t0 = edge_cnt; armed = 1; first_bclk = 0; first_dat = 0; first_valid = 0;
        cf_done_i = 1;
        repeat (4 * FRAME + 20) step();
        armed = 0;
        chk("t2_first_bclk", first_bclk - t0, 9);
        chk("t2_first_dat", first_dat - t0, 17);
        chk("t2_first_valid", first_valid - t0, FRAME + 1);
        chk("t2_first_left", first_l, 16'h8001);
        chk("t2_first_right", first_r, 16'h7FFE);

        // Starve the holding register: one frame still has data, then two underruns.
        sif.dac_valid_i = 0;
        count_un = 1; un_cnt = 0;
        repeat (3 * FRAME) step();
        count_un = 0;
        chk("t4_underruns", un_cnt, 2);

        // Random traffic and data.
        rand_cycles(5 * FRAME, 4);

        // Continuous valid: exactly one accept per frame.
        sif.dac_valid_i = 1; sif.dac_left_i = 16'h8001; sif.dac_right_i = 16'h7FFE;
        repeat (FRAME) step();
        count_acc = 1; acc_cnt = 0;
        repeat (3 * FRAME) step();
        count_acc = 0;
        chk("t5_accepts", acc_cnt, 3);

        // Drop cf_done at bit position 20 of a frame, then restart cleanly.
        for (int i = 0; i < 1100 && ((edge_cnt - (t0 + 1)) % FRAME) != 330; i++) step();
        cf_done_i = 0;
        step();
        chk("t6_bclk_low", aud_bclk, 0);
        chk("t6_lrck_low", aud_daclrck, 0);
        chk("t6_dat_low", aud_dacdat, 0);
        t_drop = 3 + int'($urandom_range(0, 17));
        repeat (t_drop) step();
        t0 = edge_cnt; armed = 1; first_bclk = 0; first_dat = 0; first_valid = 0;
        cf_done_i = 1;
        repeat (2 * FRAME + 20) step();
        armed = 0;
        chk("t6_first_bclk", first_bclk - t0, 9);
        chk("t6_first_valid", first_valid - t0, FRAME + 1);
        chk("t6_first_left", first_l, 16'h8001);

        // Reset mid-frame, then random traffic with an enable glitch.
        repeat ($urandom_range(100, 900)) step();
        rst_i = 1;
        step();
        rst_i = 0;
        rand_cycles(2 * FRAME, 3);
        en_i = 0;
        rand_cycles($urandom_range(1, 30), 2);
        en_i = 1;
        rand_cycles(2 * FRAME + 50, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
